// File: rtl/mips_pkg.sv
// Shared MIPS instruction-format definitions: field bit positions, the NOP
// encoding and the instruction word type used by fetch and decode logic.
package mips_pkg;

  typedef logic [31:0] inst_t;

  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int SHAMT_HI = 10;
  localparam int SHAMT_LO = 6;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;
  localparam int JADDR_HI = 25;
  localparam int JADDR_LO = 0;

  // sll $0,$0,0 encodes as all zeros
  localparam inst_t NOP_INST = 32'h0000_0000;

endpackage

// File: rtl/ir_fields.sv
// Purely combinational splitter of a 32-bit MIPS word into its R/I/J fields.
// Shared between the instruction queue head and the decode stage.
module ir_fields
  import mips_pkg::*;
(
  input  inst_t       i_inst,
  output logic [5:0]  o_opcode,
  output logic [4:0]  o_rs,
  output logic [4:0]  o_rt,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_shamt,
  output logic [5:0]  o_funct,
  output logic [15:0] o_imm,
  output logic [25:0] o_jaddr
);

  assign o_opcode = i_inst[OP_HI:OP_LO];
  assign o_rs     = i_inst[RS_HI:RS_LO];
  assign o_rt     = i_inst[RT_HI:RT_LO];
  assign o_rd     = i_inst[RD_HI:RD_LO];
  assign o_shamt  = i_inst[SHAMT_HI:SHAMT_LO];
  assign o_funct  = i_inst[FUNCT_HI:FUNCT_LO];
  assign o_imm    = i_inst[IMM_HI:IMM_LO];
  assign o_jaddr  = i_inst[JADDR_HI:JADDR_LO];

endmodule

// File: rtl/ir_queue.sv
// Show-ahead instruction queue between instruction memory and decode: buffers
// DEPTH PC-tagged instructions with valid/ready on both sides and a flush.
module ir_queue
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int PC_W  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_inst,
  input  logic [PC_W-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_inst,
  output logic [PC_W-1:0]            out_pc,
  output logic [5:0]                 out_opcode,
  output logic [4:0]                 out_rs,
  output logic [4:0]                 out_rt,
  output logic [4:0]                 out_rd,
  output logic [4:0]                 out_shamt,
  output logic [5:0]                 out_funct,
  output logic [15:0]                out_imm,
  output logic [25:0]                out_jaddr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_mem_inst [DEPTH];
  logic [PC_W-1:0]  r_mem_pc   [DEPTH];

  logic [PW-1:0]    w_wr_ptr_nxt;
  logic [PW-1:0]    w_rd_ptr_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_head_inst;
  logic [PC_W-1:0]  w_head_pc;
  inst_t            w_field_inst;

  // Full/empty come from the registered count only, so in_ready never
  // depends combinationally on out_ready.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = in_valid && !w_full;
  assign w_pop   = !w_empty && out_ready;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    if (flush) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
      w_count_nxt  = '0;
    end else begin
      if (w_push) w_wr_ptr_nxt = r_wr_ptr + 1'b1;
      if (w_pop)  w_rd_ptr_nxt = r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + 1'b1;
        2'b01:   w_count_nxt = r_count - 1'b1;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement or process order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
    end
  end

  // NOTE: storage has no reset; an entry is only visible once count covers
  // it, and leaving it out keeps the array mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (w_push && !flush && !rst) begin
      r_mem_inst[r_wr_ptr] <= in_inst;
      r_mem_pc[r_wr_ptr]   <= in_pc;
    end
  end

  // Empty masking presents a NOP and zero PC so decode never sees stale data.
  assign w_head_inst = w_empty ? WIDTH'(NOP_INST) : r_mem_inst[r_rd_ptr];
  assign w_head_pc   = w_empty ? '0 : r_mem_pc[r_rd_ptr];

  generate
    if (WIDTH >= 32) begin : g_field_wide
      assign w_field_inst = w_head_inst[31:0];
    end else begin : g_field_narrow
      assign w_field_inst = inst_t'(w_head_inst);
    end
  endgenerate

  ir_fields u_fields (
    .i_inst   (w_field_inst),
    .o_opcode (out_opcode),
    .o_rs     (out_rs),
    .o_rt     (out_rt),
    .o_rd     (out_rd),
    .o_shamt  (out_shamt),
    .o_funct  (out_funct),
    .o_imm    (out_imm),
    .o_jaddr  (out_jaddr)
  );

  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign out_inst  = w_head_inst;
  assign out_pc    = w_head_pc;
  assign count     = r_count;

endmodule

// File: doc/ir_queue.md
Name: ir_queue

Overview:
- Parametrised successor to the single-entry instruction register.
- Sits between instruction memory and the decode stage, and buffers up to DEPTH fetched instructions, each tagged with its PC.
- Uses a valid/ready handshake on both sides, so fetch and decode can stall independently.
- A flush input discards everything queued on a branch or jump.
- Presents the head instruction already split into MIPS fields.

Parameters:
- WIDTH, 32, instruction width in bits. Field outputs assume 32.
- PC_W, 32, width of the PC tag stored with each instruction.
- DEPTH, 4, number of entries. Must be a power of two and at least 2.

Ports:
- clk  in  1  Single clock; all state updates on its rising edge.
- rst  in  1  Reset, synchronous, active-high.
- flush  in  1  Discard all entries at the next clock edge.
- in_valid  in  1  in_inst and in_pc are valid.
- in_ready  out  1  Queue can accept an entry. Equals !full.
- in_inst  in  WIDTH  Fetched instruction.
- in_pc  in  PC_W  PC of the fetched instruction.
- out_valid  out  1  Head entry is valid. Equals !empty.
- out_ready  in  1  Decode consumes the head this cycle.
- out_inst  out  WIDTH  Head instruction; NOP (all zeros) when empty.
- out_pc  out  PC_W  Head PC; zero when empty.
- out_opcode  out  6  out_inst[31:26].
- out_rs  out  5  out_inst[25:21].
- out_rt  out  5  out_inst[20:16].
- out_rd  out  5  out_inst[15:11].
- out_shamt  out  5  out_inst[10:6].
- out_funct  out  6  out_inst[5:0].
- out_imm  out  16  out_inst[15:0].
- out_jaddr  out  26  out_inst[25:0].
- count  out  $clog2(DEPTH+1)  Number of entries held.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset:
  - Read pointer, write pointer and count go to 0.
  - After reset: out_valid=0, in_ready=1, out_inst=0, out_pc=0, count=0, all field outputs 0.
  - Storage contents need no reset.
- Push and pop:
  - Push happens when in_valid && in_ready.
  - Pop happens when out_valid && out_ready.
  - Both take effect at the rising edge.
- Organisation: show-ahead FIFO.
  - Head entry drives out_* combinationally from storage at the read pointer.
  - Latency from a push into an empty queue to out_valid=1 is one clock. There is no same-cycle bypass.
- in_ready depends only on registered state (count<DEPTH). It has no combinational path from out_ready.
  - When full, a same-cycle pop does not allow a push that cycle.
- Simultaneous push and pop when neither full nor empty: count unchanged, both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. Full and empty are derived from count.
- Pop when empty is ignored, because out_valid=0.
- Push when full is ignored, because in_ready=0. Producer data is held by the producer.
- flush:
  - At the edge, pointers and count go to 0, regardless of in_valid or out_ready that cycle.
  - A push in the flush cycle is discarded. Flush beats push.
  - A pop in the flush cycle is irrelevant.
  - out_valid=0 from the next cycle.
- rst has priority over flush. Reset mid-stream behaves identically to flush plus output clearing.
- Empty masking: out_inst and out_pc are forced to 0 when empty, so decode sees sll $0,$0,0 (NOP). Field outputs follow the masked out_inst.
- Single-entry mode: with out_ready tied high and DEPTH entries never filling, the block reproduces the old IR with one-cycle latency. The IRWrite equivalent is in_valid.

Decomposition:
- Shared package mips_pkg holds:
  - Field bit positions: OP_HI/LO, RS_HI/LO, RT_HI/LO, RD_HI/LO, SHAMT_HI/LO, FUNCT_HI/LO, IMM_HI/LO, JADDR_HI/LO.
  - NOP_INST = 32'h0000_0000.
  - Typedef inst_t (logic [31:0]).
- Sub-module ir_fields: purely combinational splitter, inst in, fields out. Reused later by the decode stage.
- ir_queue instantiates ir_fields on the masked head instruction.

Test Plan:
- Reset then idle:
  - Stimulus: rst high for 2 cycles.
  - Response: out_valid=0, in_ready=1, count=0, out_inst=0.
- Single push:
  - Stimulus: push inst 0x8C220004 (lw $2,4($1)), pc 0x00400000.
  - Response: next cycle out_valid=1, out_opcode=0x23, out_rs=1, out_rt=2, out_imm=0x0004, out_pc=0x00400000, count=1.
- Fill with decode stalled:
  - Stimulus: DEPTH=4, out_ready=0, push 0x11,0x22,0x33,0x44, then try 0x55.
  - Response: in_ready=0 after the 4th push, count=4, 0x55 is not stored.
  - Then pop all: outputs appear in order 0x11..0x44, and the queue ends empty.
- Wrap-around:
  - Stimulus: 10 cycles of continuous push and pop with in_valid=out_ready=1, data 1..10.
  - Response: count stays 1 after the first push, and outputs are 1..10 in order with no gaps.
- Flush with simultaneous push:
  - Stimulus: 3 entries held; assert flush with in_valid=1, inst 0xDEAD.
  - Response: next cycle count=0, out_valid=0, out_inst=0, and 0xDEAD is never output.
- Reset mid-operation:
  - Stimulus: 2 entries held; assert rst together with flush and push.
  - Response: next cycle all outputs are at reset values.
  - A subsequent push of 0x20080005 emerges with out_opcode=0x08, out_rt=8, out_imm=5.
